mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data-bus width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter NDEV, default 2, number of attached devices (>=2); device 0 = data memory, 1..NDEV-1 = I/O.
REQ-003 SHALL have parameter WAIT_CYC, default 2, memory wait states (1..15).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mem_req  in  1  M-stage instruction is a load or store.
REQ-007 is_store  in  1  1 = store, 0 = load.
REQ-008 size  in  2  00 byte, 01 half, 10 word, 11 dword.
REQ-009 sign_ext  in  1  load result sign-extended.
REQ-010 addr_lo  in  3  low address bits.
REQ-011 dev_idx  in  clog2(NDEV)  target device index.
REQ-012 mem_ready  in  1  memory early-completion strobe.
REQ-013 be  out  DATA_W/8  byte-lane enables, little-endian.
REQ-014 me_op  out  3  load-extension op {~sign_ext, size}; 000 when no load strobe.
REQ-015 dev_wr  out  NDEV  one-hot write strobe.
REQ-016 dev_rd  out  NDEV  one-hot read strobe.
REQ-017 stall  out  1  freeze pipeline upstream of M.
REQ-018 dm_work  out  1  memory access completing this cycle.
REQ-019 addr_fault  out  1  current request illegal.
REQ-020 fault_cnt  out  8  saturating count of illegal requests.

Function
REQ-021 Request SHALL be illegal when: size=01 and addr_lo[0]!=0; size=10 and addr_lo[1:0]!=0; size=11 and (DATA_W=32 or addr_lo[2:0]!=0); or dev_idx>=NDEV.
REQ-022 addr_fault SHALL be combinational = mem_req & illegal & (state==IDLE) & ~reset.
REQ-023 Illegal request SHALL produce no strobes, no stall; fault_cnt increments by 1 per cycle with addr_fault=1, saturating at 255.
REQ-024 be SHALL equal ((1<<(1<<size))-1) << byte offset (addr_lo modulo DATA_W/8) for legal requests, else 0.
REQ-025 States IDLE, WAIT, DONE; counter cnt, 4 bits.
REQ-026 IDLE, legal mem_req to device k!=0: dev_wr[k] or dev_rd[k] asserted this cycle only, stall=0, stay IDLE.
REQ-027 IDLE, legal mem_req to device 0: strobe[0] and stall=1 this cycle; if WAIT_CYC=1 or mem_ready=1 next state DONE, else WAIT with cnt=WAIT_CYC-1.
REQ-028 WAIT: strobe[0], be, me_op held, stall=1; if mem_ready=1 or cnt=1 next DONE, else cnt decrements.
REQ-029 Total stall for a memory access SHALL be WAIT_CYC cycles without mem_ready; minimum 1.
REQ-030 DONE: stall=0, dm_work=1, all strobes 0, request inputs ignored; next state IDLE unconditionally.
REQ-031 Upstream SHALL hold inputs stable while stall=1; block does not re-sample in WAIT.
REQ-032 dm_work SHALL be 1 only in DONE.
REQ-033 mem_req=0 in IDLE: all outputs except fault_cnt are 0.

Reset
REQ-034 At a clock edge with reset=1: state=IDLE, cnt=0, fault_cnt=0.
REQ-035 While reset=1 all combinational outputs (be, me_op, strobes, stall, dm_work, addr_fault) SHALL be 0.
REQ-036 Reset asserted during WAIT SHALL abort the access; no DONE, dm_work never pulses for it.

Verification
REQ-037 WAIT_CYC=2, sw addr_lo=000 dev 0 -> be=1111, dev_wr=01, stall=1 for 2 cycles, then dm_work=1 one cycle, then IDLE.
REQ-038 lbu addr_lo=011 dev 1 -> be=1000, dev_rd=10, me_op=100, stall=0, single cycle.
REQ-039 WAIT_CYC=4, lh dev 0, mem_ready=1 in 2nd cycle -> stall 2 cycles, DONE next.
REQ-040 lw addr_lo=010 -> addr_fault=1, no strobes, fault_cnt 0->1; 300 repeats -> fault_cnt=255.
REQ-041 DATA_W=64, sd addr_lo=000 -> be=8'hFF; DATA_W=32 sd -> addr_fault=1.
REQ-042 reset pulse during WAIT -> next cycle IDLE, stall=0, dm_work stays 0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_ctrl
//  Purpose  : M-stage load/store controller. Decodes the access size and low
//             address bits into byte-lane enables and a load-extension op,
//             steers a one-hot read/write strobe to the addressed device, and
//             stalls the pipeline while the data memory (device 0) works
//             through its wait states. Misaligned or out-of-range requests
//             are flagged and counted instead of being issued.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             mem_req, is_store   - request valid, store(1)/load(0)
//             size, sign_ext      - access size code, load sign extension
//             addr_lo, dev_idx    - low address bits, target device
//             mem_ready           - memory early-completion strobe
//             be, me_op           - byte-lane enables, load-extension op
//             dev_wr, dev_rd      - one-hot device write/read strobes
//             stall, dm_work      - pipeline freeze, memory access completing
//             addr_fault          - current request illegal
//             fault_cnt           - saturating illegal-request count
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int DATA_W   = 32,
  parameter int NDEV     = 2,
  parameter int WAIT_CYC = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_req,
  input  logic                     is_store,
  input  logic [1:0]               size,
  input  logic                     sign_ext,
  input  logic [2:0]               addr_lo,
  input  logic [$clog2(NDEV)-1:0]  dev_idx,
  input  logic                     mem_ready,
  output logic [DATA_W/8-1:0]      be,
  output logic [2:0]               me_op,
  output logic [NDEV-1:0]          dev_wr,
  output logic [NDEV-1:0]          dev_rd,
  output logic                     stall,
  output logic                     dm_work,
  output logic                     addr_fault,
  output logic [7:0]               fault_cnt
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          fault_cnt_q;
  // Request attributes captured when a memory access starts, so the WAIT
  // state replays them without looking at the request inputs again.
  logic [BE_W-1:0]     op_be_q;
  logic [2:0]          op_meop_q;
  logic                op_store_q;

  logic                w_illegal;
  logic [3:0]          w_off;
  logic [3:0]          w_nbytes;
  logic [BE_W-1:0]     w_be_leg;
  logic                w_mem_start;

  // Alignment and device-range check.
  always_comb begin
    w_illegal = 1'b0;
    unique case (size)
      2'b01:   w_illegal = addr_lo[0];
      2'b10:   w_illegal = |addr_lo[1:0];
      2'b11:   w_illegal = (DATA_W == 32) || (|addr_lo);
      default: w_illegal = 1'b0;
    endcase
    if (32'(dev_idx) >= 32'(NDEV)) begin
      w_illegal = 1'b1;
    end
  end

  // Lane mask: a run of 2^size ones starting at the byte offset within the
  // bus word. Only meaningful for legal requests, which never overflow.
  always_comb begin
    w_off    = {1'b0, addr_lo} & 4'(BE_W - 1);
    w_nbytes = 4'd1 << size;
    w_be_leg = '0;
    for (int b = 0; b < BE_W; b++) begin
      w_be_leg[b] = (4'(b) >= w_off) && (4'(b) < (w_off + w_nbytes));
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    be          = '0;
    me_op       = 3'b000;
    dev_wr      = '0;
    dev_rd      = '0;
    stall       = 1'b0;
    dm_work     = 1'b0;
    addr_fault  = 1'b0;
    w_mem_start = 1'b0;

    if (!reset) begin
      unique case (state_q)
        ST_IDLE: begin
          if (mem_req) begin
            if (w_illegal) begin
              addr_fault = 1'b1;
            end else begin
              be = w_be_leg;
              if (is_store) begin
                dev_wr[dev_idx] = 1'b1;
              end else begin
                dev_rd[dev_idx] = 1'b1;
                me_op           = {~sign_ext, size};
              end
              // Only the data memory has wait states; I/O completes now.
              if (dev_idx == '0) begin
                stall       = 1'b1;
                w_mem_start = 1'b1;
                if ((WAIT_CYC == 1) || mem_ready) begin
                  state_d = ST_DONE;
                end else begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'(WAIT_CYC - 1);
                end
              end
            end
          end
        end

        ST_WAIT: begin
          be    = op_be_q;
          me_op = op_meop_q;
          stall = 1'b1;
          if (op_store_q) begin
            dev_wr[0] = 1'b1;
          end else begin
            dev_rd[0] = 1'b1;
          end
          if (mem_ready || (cnt_q == 4'd1)) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end

        ST_DONE: begin
          dm_work = 1'b1;
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      fault_cnt_q <= 8'd0;
      op_be_q     <= '0;
      op_meop_q   <= 3'b000;
      op_store_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (addr_fault && (fault_cnt_q != 8'hFF)) begin
        fault_cnt_q <= fault_cnt_q + 8'd1;
      end
      if (w_mem_start) begin
        op_be_q    <= be;
        op_meop_q  <= me_op;
        op_store_q <= is_store;
      end
    end
  end

  assign fault_cnt = fault_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_ctrl
//  Purpose  : Self-checking bench for mem_access_ctrl. Two instances:
//             A = 32-bit bus, 2 devices, 2 wait states
//             B = 64-bit bus, 3 devices, 4 wait states
//             A vector table covers decode and strobes; hand sequences cover
//             early completion, reset abort and fault-count saturation.
//             Expected stall lengths are queued per access and checked when
//             dm_work appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, req_a, req_b, is_store, sign_ext, mem_ready;
  logic [1:0] size;
  logic [2:0] addr_lo;
  logic       dev_a;
  logic [1:0] dev_b;

  logic [3:0] be_a;   logic [2:0] meop_a; logic [1:0] wr_a, rd_a;
  logic       stall_a, dm_a, flt_a;       logic [7:0] fcnt_a;
  logic [7:0] be_b;   logic [2:0] meop_b; logic [2:0] wr_b, rd_b;
  logic       stall_b, dm_b, flt_b;       logic [7:0] fcnt_b;

  mem_access_ctrl #(.DATA_W(32), .NDEV(2), .WAIT_CYC(2)) u_a (
    .clk(clk), .reset(reset), .mem_req(req_a), .is_store(is_store),
    .size(size), .sign_ext(sign_ext), .addr_lo(addr_lo), .dev_idx(dev_a),
    .mem_ready(mem_ready), .be(be_a), .me_op(meop_a), .dev_wr(wr_a),
    .dev_rd(rd_a), .stall(stall_a), .dm_work(dm_a), .addr_fault(flt_a),
    .fault_cnt(fcnt_a)
  );

  mem_access_ctrl #(.DATA_W(64), .NDEV(3), .WAIT_CYC(4)) u_b (
    .clk(clk), .reset(reset), .mem_req(req_b), .is_store(is_store),
    .size(size), .sign_ext(sign_ext), .addr_lo(addr_lo), .dev_idx(dev_b),
    .mem_ready(mem_ready), .be(be_b), .me_op(meop_b), .dev_wr(wr_b),
    .dev_rd(rd_b), .stall(stall_b), .dm_work(dm_b), .addr_fault(flt_b),
    .fault_cnt(fcnt_b)
  );

  int total = 0;
  int bad   = 0;
  int q_a[$];
  int q_b[$];
  int run_a = 0;
  int run_b = 0;
  int exp_fc_a = 0;
  int exp_fc_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stall-length scoreboards: count stalled cycles, compare on dm_work.
  always @(negedge clk) begin
    #3;
    if (reset) begin
      run_a = 0;
    end else begin
      if (stall_a) run_a++;
      if (dm_a) begin
        if (q_a.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_dm_work: got 1 expected 0");
        end else begin
          chk("a_stall_len", 32'(run_a), 32'(q_a.pop_front()));
        end
        run_a = 0;
      end
    end
  end

  always @(negedge clk) begin
    #3;
    if (reset) begin
      run_b = 0;
    end else begin
      if (stall_b) run_b++;
      if (dm_b) begin
        if (q_b.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_dm_work: got 1 expected 0");
        end else begin
          chk("b_stall_len", 32'(run_b), 32'(q_b.pop_front()));
        end
        run_b = 0;
      end
    end
  end

  typedef struct {
    bit         b;     // 0 = instance A, 1 = instance B
    logic       st;
    logic [1:0] sz;
    logic       sx;
    logic [2:0] ad;
    logic [1:0] dv;
    logic [7:0] ebe;
    logic [2:0] eop;
    logic [2:0] ewr;
    logic [2:0] erd;
    logic       estall;
    logic       eflt;
    int         ecyc;
  } vec_t;

  vec_t vt[15];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a_be;
    logic [2:0] a_op, a_wr, a_rd;
    logic       a_st, a_fl;
    bit         timed_out;

    //          b  st sz     sx ad      dv     be     op      wr      rd      stl flt cyc
    vt[0]  = '{0, 1, 2'b10, 0, 3'b000, 2'd0, 8'h0F, 3'b000, 3'b001, 3'b000, 1, 0, 2}; // sw mem
    vt[1]  = '{0, 0, 2'b00, 0, 3'b011, 2'd1, 8'h08, 3'b100, 3'b000, 3'b010, 0, 0, 0}; // lbu io
    vt[2]  = '{0, 0, 2'b00, 1, 3'b001, 2'd1, 8'h02, 3'b000, 3'b000, 3'b010, 0, 0, 0}; // lb io
    vt[3]  = '{0, 0, 2'b01, 1, 3'b010, 2'd0, 8'h0C, 3'b001, 3'b000, 3'b001, 1, 0, 2}; // lh mem
    vt[4]  = '{0, 0, 2'b01, 0, 3'b001, 2'd0, 8'h00, 3'b000, 3'b000, 3'b000, 0, 1, 0}; // lhu odd
    vt[5]  = '{0, 0, 2'b10, 1, 3'b010, 2'd0, 8'h00, 3'b000, 3'b000, 3'b000, 0, 1, 0}; // lw mis
    vt[6]  = '{0, 1, 2'b11, 0, 3'b000, 2'd0, 8'h00, 3'b000, 3'b000, 3'b000, 0, 1, 0}; // sd 32b
    vt[7]  = '{0, 1, 2'b00, 0, 3'b111, 2'd1, 8'h08, 3'b000, 3'b010, 3'b000, 0, 0, 0}; // sb io
    vt[8]  = '{0, 0, 2'b10, 1, 3'b100, 2'd1, 8'h0F, 3'b010, 3'b000, 3'b010, 0, 0, 0}; // lw io
    vt[9]  = '{1, 1, 2'b11, 0, 3'b000, 2'd0, 8'hFF, 3'b000, 3'b001, 3'b000, 1, 0, 4}; // sd mem
    vt[10] = '{1, 0, 2'b10, 0, 3'b100, 2'd2, 8'hF0, 3'b110, 3'b000, 3'b100, 0, 0, 0}; // lwu io2
    vt[11] = '{1, 1, 2'b01, 0, 3'b110, 2'd1, 8'hC0, 3'b000, 3'b010, 3'b000, 0, 0, 0}; // sh io1
    vt[12] = '{1, 0, 2'b00, 1, 3'b000, 2'd3, 8'h00, 3'b000, 3'b000, 3'b000, 0, 1, 0}; // bad dev
    vt[13] = '{1, 1, 2'b11, 0, 3'b100, 2'd0, 8'h00, 3'b000, 3'b000, 3'b000, 0, 1, 0}; // sd mis
    vt[14] = '{1, 0, 2'b11, 1, 3'b000, 2'd0, 8'hFF, 3'b011, 3'b000, 3'b001, 1, 0, 4}; // ld mem

    // Reset with a live request: every output must read zero.
    reset = 1'b1; req_a = 1'b1; req_b = 1'b0; is_store = 1'b1; size = 2'b10;
    sign_ext = 1'b0; addr_lo = 3'b000; dev_a = 1'b0; dev_b = 2'd0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_be",    32'(be_a),    32'h0);
    chk("rst_wr",    32'(wr_a),    32'h0);
    chk("rst_stall", 32'(stall_a), 32'h0);
    chk("rst_fcnt",  32'(fcnt_a),  32'h0);
    @(negedge clk);
    reset = 1'b0; req_a = 1'b0;
    #2;
    chk("idle_be",    32'(be_a),    32'h0);
    chk("idle_stall", 32'(stall_a), 32'h0);
    chk("idle_dm",    32'(dm_a),    32'h0);

    // Table-driven vectors.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      is_store = vt[i].st; size = vt[i].sz; sign_ext = vt[i].sx; addr_lo = vt[i].ad;
      if (vt[i].b) begin dev_b = vt[i].dv;    req_b = 1'b1; end
      else         begin dev_a = vt[i].dv[0]; req_a = 1'b1; end
      #2;
      a_be = vt[i].b ? be_b    : {4'h0, be_a};
      a_op = vt[i].b ? meop_b  : meop_a;
      a_wr = vt[i].b ? wr_b    : {1'b0, wr_a};
      a_rd = vt[i].b ? rd_b    : {1'b0, rd_a};
      a_st = vt[i].b ? stall_b : stall_a;
      a_fl = vt[i].b ? flt_b   : flt_a;
      chk($sformatf("v%0d_be", i),    32'(a_be), 32'(vt[i].ebe));
      chk($sformatf("v%0d_meop", i),  32'(a_op), 32'(vt[i].eop));
      chk($sformatf("v%0d_wr", i),    32'(a_wr), 32'(vt[i].ewr));
      chk($sformatf("v%0d_rd", i),    32'(a_rd), 32'(vt[i].erd));
      chk($sformatf("v%0d_stall", i), 32'(a_st), 32'(vt[i].estall));
      chk($sformatf("v%0d_fault", i), 32'(a_fl), 32'(vt[i].eflt));
      if (vt[i].estall) begin
        if (vt[i].b) q_b.push_back(vt[i].ecyc);
        else         q_a.push_back(vt[i].ecyc);
        timed_out = 1'b1;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          #2;
          if (!(vt[i].b ? stall_b : stall_a)) begin
            timed_out = 1'b0;
            break;
          end
        end
        if (timed_out) begin
          total++; bad++;
          $display("FAIL v%0d_stall_timeout: stall still 1 after 20 cycles", i);
        end
      end else begin
        @(negedge clk);
      end
      req_a = 1'b0; req_b = 1'b0;
      if (vt[i].eflt) begin
        if (vt[i].b) exp_fc_b++;
        else         exp_fc_a++;
      end
      @(negedge clk);
      #2;
      if (vt[i].b) chk($sformatf("v%0d_fcnt", i), 32'(fcnt_b), 32'(exp_fc_b));
      else         chk($sformatf("v%0d_fcnt", i), 32'(fcnt_a), 32'(exp_fc_a));
    end

    // B: lh to memory, mem_ready in the second stalled cycle -> 2 stall cycles.
    @(negedge clk);
    is_store = 1'b0; size = 2'b01; sign_ext = 1'b1; addr_lo = 3'b000; dev_b = 2'd0; req_b = 1'b1;
    q_b.push_back(2);
    #2;
    chk("er_stall0", 32'(stall_b), 32'h1);
    chk("er_be0",    32'(be_b),    32'h03);
    chk("er_meop0",  32'(meop_b),  32'h1);
    @(negedge clk);
    mem_ready = 1'b1;
    #2;
    chk("er_stall1", 32'(stall_b), 32'h1);
    chk("er_rd1",    32'(rd_b),    32'h1);
    chk("er_meop1",  32'(meop_b),  32'h1);
    @(negedge clk);
    mem_ready = 1'b0;
    #2;
    chk("er_dm",     32'(dm_b),    32'h1);
    chk("er_stall2", 32'(stall_b), 32'h0);
    chk("er_rd2",    32'(rd_b),    32'h0);
    req_b = 1'b0;
    @(negedge clk);
    #2;
    chk("er_dm_off", 32'(dm_b), 32'h0);

    // B: mem_ready already in the request cycle -> minimum 1 stall cycle.
    @(negedge clk);
    is_store = 1'b1; size = 2'b00; addr_lo = 3'b101; dev_b = 2'd0; req_b = 1'b1; mem_ready = 1'b1;
    q_b.push_back(1);
    #2;
    chk("min_stall", 32'(stall_b), 32'h1);
    chk("min_be",    32'(be_b),    32'h20);
    chk("min_wr",    32'(wr_b),    32'h1);
    @(negedge clk);
    mem_ready = 1'b0;
    #2;
    chk("min_dm",    32'(dm_b),    32'h1);
    req_b = 1'b0;
    @(negedge clk);

    // A: reset pulse while waiting aborts the access; no dm_work may follow.
    @(negedge clk);
    is_store = 1'b1; size = 2'b10; addr_lo = 3'b000; dev_a = 1'b0; req_a = 1'b1;
    #2;
    chk("ab_stall0", 32'(stall_a), 32'h1);
    @(negedge clk);
    #2;
    chk("ab_stall1", 32'(stall_a), 32'h1);
    reset = 1'b1;
    #1;
    chk("ab_rst_stall", 32'(stall_a), 32'h0);
    chk("ab_rst_wr",    32'(wr_a),    32'h0);
    @(negedge clk);
    reset = 1'b0; req_a = 1'b0;
    exp_fc_a = 0;
    #2;
    chk("ab_stall2", 32'(stall_a), 32'h0);
    chk("ab_dm",     32'(dm_a),    32'h0);
    chk("ab_fcnt",   32'(fcnt_a),  32'(exp_fc_a));
    repeat (4) @(negedge clk);

    // A: misaligned lw held for 300 cycles -> count saturates at 255.
    @(negedge clk);
    is_store = 1'b0; size = 2'b10; addr_lo = 3'b010; dev_a = 1'b0; req_a = 1'b1;
    #2;
    chk("sat_fault", 32'(flt_a),   32'h1);
    chk("sat_rd",    32'(rd_a),    32'h0);
    chk("sat_stall", 32'(stall_a), 32'h0);
    @(negedge clk);
    #2;
    chk("sat_fcnt1", 32'(fcnt_a), 32'(exp_fc_a + 1));
    repeat (299) @(negedge clk);
    req_a = 1'b0;
    exp_fc_a = (exp_fc_a + 300 > 255) ? 255 : exp_fc_a + 300;
    #2;
    chk("sat_fcnt", 32'(fcnt_a), 32'(exp_fc_a));
    @(negedge clk);
    #2;
    chk("sat_hold", 32'(fcnt_a), 32'(exp_fc_a));

    repeat (3) @(negedge clk);
    chk("a_pending", 32'(q_a.size()), 32'h0);
    chk("b_pending", 32'(q_b.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
